// File: rtl/pll_lock_sequencer.sv
// PLL power-up sequencer: pulses pll_rst, waits for lock, qualifies it,
// then releases the core reset; retries on timeout, counts lock losses.
// Ports: refclk/rst (sync, active-high), pll_locked (async), soft_rst;
// pll_rst, sys_reset, ready, state, retry_cnt, fail, loss_cnt.
// Build option: define PLLSEQ_TIMEOUT_EN for WAIT timeout and retries.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7,
  parameter int CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [1:0] state,
  output logic [3:0] retry_cnt,
  output logic       fail,
  output logic [7:0] loss_cnt
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_WAIT   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic [7:0]       loss_q, loss_d;
  logic             lk;

  // Lock only ever seen through the two-flop synchroniser.
  assign lk = sync_q[1];

`ifdef PLLSEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0] RETRY_MAX =
    4'(MAX_RETRY);
  logic [3:0] retry_q, retry_d;
  logic       fail_q, fail_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^{LOCK_TIMEOUT, MAX_RETRY};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
`ifdef PLLSEQ_TIMEOUT_EN
    retry_d = retry_q;
    fail_d  = fail_q;
`endif
    unique case (state_q)
      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (lk) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
`ifdef PLLSEQ_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = S_RESET;
          cnt_d   = '0;
          if (retry_q != 4'hf)
            retry_d = retry_q + 4'd1;
          fail_d = fail_q | (retry_d >= RETRY_MAX);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      S_SETTLE: begin
        // Any glitch restarts qualification from scratch.
        if (!lk) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == SET_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        // Lock loss wins over a simultaneous soft reset.
        if (!lk) begin
          state_d = S_RESET;
          cnt_d   = '0;
          if (loss_q != 8'hff)
            loss_d = loss_q + 8'd1;
        end else if (soft_rst) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      sync_q    <= '0;
      loss_q    <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= {sync_q[0], pll_locked};
      loss_q    <= loss_d;
      pll_rst   <= (state_d == S_RESET);
      sys_reset <= (state_d != S_RUN);
      ready     <= (state_d == S_RUN);
    end
  end

`ifdef PLLSEQ_TIMEOUT_EN
  always_ff @(posedge refclk) begin
    if (rst) begin
      retry_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      retry_q <= retry_d;
      fail_q  <= fail_d;
    end
  end

  assign retry_cnt = retry_q;
  assign fail      = fail_q;
`else
  assign retry_cnt = 4'd0;
  assign fail      = 1'b0;
`endif

  assign state    = state_q;
  assign loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small cycle parameters.
// Inputs change 1 ns after a rising edge; outputs checked at that point.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       soft_rst;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [1:0] state;
  logic [3:0] retry_cnt;
  logic       fail;
  logic [7:0] loss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [1:0] RESET  = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] RUN    = 2'd3;

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .SETTLE_CYCLES (8),
    .MAX_RETRY     (3),
    .CNT_W         (16)
  ) dut (
    .refclk     (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .soft_rst   (soft_rst),
    .pll_rst    (pll_rst),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .state      (state),
    .retry_cnt  (retry_cnt),
    .fail       (fail),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, " state"},     32'(state),     32'(RESET));
    chk({tag, " pll_rst"},   32'(pll_rst),   32'd1);
    chk({tag, " sys_reset"}, 32'(sys_reset), 32'd1);
    chk({tag, " ready"},     32'(ready),     32'd0);
    chk({tag, " retry"},     32'(retry_cnt), 32'd0);
    chk({tag, " fail"},      32'(fail),      32'd0);
    chk({tag, " loss"},      32'(loss_cnt),  32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    soft_rst   = 1'b0;
    tick(2);
    chk_rst_vals("por");

    // Power-up: cycle 0 is the first cycle with rst low.
    rst = 1'b0;
    chk("c0 pll_rst", 32'(pll_rst), 32'd1);
    tick(3);
    chk("c3 pll_rst", 32'(pll_rst), 32'd1);
    tick(1);
    chk("c4 state", 32'(state), 32'(WAIT));
    chk("c4 pll_rst", 32'(pll_rst), 32'd0);
    tick(1);
    pll_locked = 1'b1;
    tick(2);
    chk("c7 state", 32'(state), 32'(WAIT));
    tick(1);
    chk("c8 state", 32'(state), 32'(SETTLE));
    tick(7);
    chk("c15 state", 32'(state), 32'(SETTLE));
    chk("c15 sys_reset", 32'(sys_reset), 32'd1);
    tick(1);
    chk("c16 state", 32'(state), 32'(RUN));
    chk("c16 ready", 32'(ready), 32'd1);
    chk("c16 sys_reset", 32'(sys_reset), 32'd0);

    // Soft reset: 8 cycles of SETTLE, PLL untouched.
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("soft state", 32'(state), 32'(SETTLE));
    chk("soft sys_reset", 32'(sys_reset), 32'd1);
    chk("soft pll_rst", 32'(pll_rst), 32'd0);
    tick(7);
    chk("soft+7 sys_reset", 32'(sys_reset), 32'd1);
    tick(1);
    chk("soft+8 state", 32'(state), 32'(RUN));
    chk("soft+8 sys_reset", 32'(sys_reset), 32'd0);
    chk("soft loss", 32'(loss_cnt), 32'd0);

    // One-cycle lock glitch inside SETTLE.
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    tick(2);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    chk("glitch s4", 32'(state), 32'(SETTLE));
    tick(1);
    chk("glitch s5", 32'(state), 32'(WAIT));
    tick(1);
    chk("glitch s6", 32'(state), 32'(SETTLE));
    tick(7);
    chk("glitch s13", 32'(state), 32'(SETTLE));
    tick(1);
    chk("glitch s14", 32'(state), 32'(RUN));

    // Lock loss in RUN.
    pll_locked = 1'b0;
    tick(2);
    chk("loss r2 state", 32'(state), 32'(RUN));
    tick(1);
    chk("loss r3 state", 32'(state), 32'(RESET));
    chk("loss r3 sys_reset", 32'(sys_reset), 32'd1);
    chk("loss r3 ready", 32'(ready), 32'd0);
    chk("loss r3 pll_rst", 32'(pll_rst), 32'd1);
    chk("loss r3 cnt", 32'(loss_cnt), 32'd1);
    tick(3);
    chk("loss r6 pll_rst", 32'(pll_rst), 32'd1);
    tick(1);
    chk("loss r7 pll_rst", 32'(pll_rst), 32'd0);
    chk("loss r7 state", 32'(state), 32'(WAIT));

`ifdef PLLSEQ_TIMEOUT_EN
    // Lock withheld: timeout every 24 cycles.
    tick(19);
    chk("to r26 state", 32'(state), 32'(WAIT));
    chk("to r26 retry", 32'(retry_cnt), 32'd0);
    tick(1);
    chk("to r27 state", 32'(state), 32'(RESET));
    chk("to r27 retry", 32'(retry_cnt), 32'd1);
    chk("to r27 fail", 32'(fail), 32'd0);
    tick(24);
    chk("to r51 retry", 32'(retry_cnt), 32'd2);
    chk("to r51 pll_rst", 32'(pll_rst), 32'd1);
    tick(23);
    chk("to r74 fail", 32'(fail), 32'd0);
    tick(1);
    chk("to r75 retry", 32'(retry_cnt), 32'd3);
    chk("to r75 fail", 32'(fail), 32'd1);
    tick(24);
    chk("to r99 retry", 32'(retry_cnt), 32'd4);
    chk("to r99 fail", 32'(fail), 32'd1);
    chk("to r99 pll_rst", 32'(pll_rst), 32'd1);
`else
    // No timeout: WAIT holds indefinitely.
    tick(100);
    chk("nto state", 32'(state), 32'(WAIT));
    chk("nto pll_rst", 32'(pll_rst), 32'd0);
    chk("nto retry", 32'(retry_cnt), 32'd0);
    chk("nto fail", 32'(fail), 32'd0);
`endif

    // Fresh start with lock present, then loss + soft_rst together.
    rst = 1'b1;
    tick(1);
    rst        = 1'b0;
    pll_locked = 1'b1;
    tick(5);
    chk("re c5 state", 32'(state), 32'(SETTLE));
    tick(8);
    chk("re c13 state", 32'(state), 32'(RUN));
    pll_locked = 1'b0;
    tick(2);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("both state", 32'(state), 32'(RESET));
    chk("both loss", 32'(loss_cnt), 32'd1);
    chk("both pll_rst", 32'(pll_rst), 32'd1);

    // rst in the middle of SETTLE.
    pll_locked = 1'b1;
    tick(7);
    chk("mid q10 state", 32'(state), 32'(SETTLE));
    rst = 1'b1;
    tick(1);
    chk_rst_vals("mid rst");
    rst = 1'b0;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
